fm_modulate: RTL and testbench
==============================

# fm_modulate

Streaming FM modulator, the transmit-side counterpart of the FM demodulator. Takes signed 16-bit audio samples on an AXI-Stream slave and holds each one for `INTERP` output beats. On every beat it adds the scaled sample to a wrapping 16-bit phase accumulator and emits polar samples on an AXI-Stream master: `{phase, magnitude}`. This is the same word layout the CORDIC stage delivers to the demodulator, so a modulator-to-demodulator loopback recovers the per-beat phase increment.

## Interface
Parameters:
- `C_S00_AXIS_TDATA_WIDTH`, 32, slave data width; only `[15:0]` is used.
- `C_M00_AXIS_TDATA_WIDTH`, 32, master data width.
- `INTERP`, 4, output beats per input sample; must be ≥1.
- `K_SHIFT`, 0, arithmetic right shift applied to the sample to form the phase increment (deviation gain); range 0–15.
- `AMPLITUDE`, 16'h7FFF, constant magnitude placed in `m00_axis_tdata[15:0]`.

Ports:
- `s00_axis_aclk`  in  1  the single clock.
- `s00_axis_areset`  in  1  reset; one clock, reset is asynchronous and active-high.
- `s00_axis_tvalid`  in  1  input sample valid.
- `s00_axis_tdata`  in  C_S00_AXIS_TDATA_WIDTH  `[15:0]` signed audio sample; upper bits ignored.
- `s00_axis_tstrb`  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
- `s00_axis_tlast`  in  1  end of input packet.
- `s00_axis_tready`  out  1  sample accepted when high with tvalid.
- `m00_axis_tready`  in  1  downstream ready.
- `m00_axis_tvalid`  out  1  output beat valid.
- `m00_axis_tdata`  out  C_M00_AXIS_TDATA_WIDTH  `[31:16]` phase (two's-complement, full scale ±π), `[15:0]` AMPLITUDE.
- `m00_axis_tstrb`  out  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid.
- `m00_axis_tlast`  out  1  last beat of the last held sample of a packet.

## Operation
- Internal state:
  - `held_valid`, `held_inc[15:0]`, `held_last`.
  - `beat_cnt` (`$clog2(INTERP)` bits, minimum 1).
  - `phase[15:0]`.
  - Output register set.
- Increment: `held_inc = $signed(sample) >>> K_SHIFT`, sign preserved, computed at acceptance.
- `out_free = !m00_axis_tvalid || m00_axis_tready`.
- `s00_axis_tready = !held_valid || (out_free && beat_cnt == INTERP-1)` (combinational).
- Beat emission happens when `held_valid && out_free`:
  - `phase <= phase + held_inc` (mod 2^16).
  - `m00_axis_tdata <= {phase + held_inc, AMPLITUDE}`.
  - `m00_axis_tvalid <= 1`.
  - `m00_axis_tlast <= held_last && beat_cnt == INTERP-1`.
  - `beat_cnt` increments; it clears to 0 on the final beat.
- On the final beat, `held_valid` clears unless a new sample is accepted the same cycle. In that case the new sample loads and emission continues back-to-back.
- If there is no emission and the output handshake completes, `m00_axis_tvalid <= 0`.
- When `m00_axis_tvalid && !m00_axis_tready`, all `m00_*` outputs hold stable.
- Effective states:
  - IDLE (`!held_valid`): ready, no emission.
  - RUN (`held_valid`): emitting beats.
  - RUN→IDLE on the final beat with no new input.
  - IDLE→RUN on acceptance.
- Phase is continuous across samples and packets; only reset clears it.

## Timing
- All outputs are registered except `s00_axis_tready`.
- Reset values: `m00_axis_tvalid=0`, `m00_axis_tdata=0`, `m00_axis_tstrb=0`, `m00_axis_tlast=0`, `phase=0`, `held_valid=0`, `beat_cnt=0`. `s00_axis_tready` is therefore 1 out of reset.
- Reset asserted mid-operation discards the held sample and any un-accepted output beat, and zeroes the phase.
- Latency: a sample accepted at edge N produces its first beat valid after edge N+1.
- Throughput: one beat per cycle when downstream is always ready. The input is accepted once per INTERP cycles; with INTERP=1, one sample per cycle.
- Overflow wraps silently, e.g. 0x7000+0x7000 = 0xE000. No saturation.

## Structure
- Package `fm_pkg`:
  - `PHASE_W=16`, `MAG_W=16`.
  - `typedef logic signed [15:0] angle_t`.
  - `typedef logic [15:0] mag_t`.
  - Helper constant `ANGLE_PI=16'h7FFF`, shared with the demodulator.
- One sub-module: `phase_accumulator`.
  - Ports: clock, async reset, enable, `angle_t inc`, `angle_t phase_next`.
  - Implements the registered wrap-around add.
- The handshake, hold logic and beat counter stay in `fm_modulate`.

## Test plan
- INTERP=4, K_SHIFT=0, tready=1; send one sample 0x0100 → four beats with tdata[31:16] = 0x0100, 0x0200, 0x0300, 0x0400; tdata[15:0] = 0x7FFF; s00 tready low for 3 cycles after acceptance.
- Wrap: from reset, sample 0x7000 → phases 0x7000, 0xE000, 0x5000, 0xC000. Then sample 0xFF00 (−256) → 0xBF00, 0xBE00, 0xBD00, 0xBC00.
- K_SHIFT=4, sample 0x8000 → increment 0xF800; beats 0xF800, 0xF000, 0xE800, 0xE000.
- Backpressure: hold m00 tready low 5 cycles mid-sample → tdata/tlast stable; no beat lost or duplicated; phase sequence is identical to the unstalled run.
- tlast: 3-sample packet with tlast on the third → m00 tlast high only on beat 12. Back-to-back input keeps m00 tvalid continuously high.
- Reset mid-sample after beat 2 → outputs zero within the reset; s00 tready=1; the next sample 0x0010 yields first phase 0x0010.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and constants for the FM modulator / demodulator pair.
// Angles are two's-complement with full scale +/-pi; magnitudes are unsigned.
package fm_pkg;

  localparam int PHASE_W = 16;
  localparam int MAG_W   = 16;

  typedef logic signed [PHASE_W-1:0] angle_t;
  typedef logic        [MAG_W-1:0]   mag_t;

  localparam angle_t ANGLE_PI = 16'h7FFF;

  // IDLE: no sample held; RUN: emitting the held sample's beats.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mod_state_t;

endpackage

// File: rtl/fm_modulate_if.sv
// AXI-Stream channel bundle used on both sides of the modulator.
interface fm_modulate_if #(
  parameter int DATA_W = 32
);

  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic [DATA_W/8-1:0]   tstrb;
  logic                  tlast;

  modport master (
    output tvalid, tdata, tstrb, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tstrb, tlast,
    output tready
  );

endinterface

// File: rtl/fm_modulate_phase_accumulator.sv
// Wrapping phase register: advances by inc when enabled and exposes the
// post-add value so the caller can register it alongside the phase.
module phase_accumulator
  import fm_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   en,
  input  angle_t inc,
  output angle_t phase_next
);

  angle_t phase;

  // Two's-complement add drops the carry, which is exactly the 2*pi wrap.
  assign phase_next = phase + inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/fm_modulate.sv
// Streaming FM modulator: each audio sample is held for INTERP beats, each
// beat advancing the phase by the scaled sample and emitting {phase, magnitude}.
module fm_modulate
  import fm_pkg::*;
#(
  parameter int   C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int   C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int   INTERP                 = 4,
  parameter int   K_SHIFT                = 0,
  parameter mag_t AMPLITUDE              = 16'h7FFF
) (
  input  logic          s00_axis_aclk,
  input  logic          s00_axis_areset,
  fm_modulate_if.slave  s00_axis,
  fm_modulate_if.master m00_axis
);

  localparam int               CNT_W    = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(INTERP - 1);
  localparam int               STRB_W   = C_M00_AXIS_TDATA_WIDTH / 8;

  mod_state_t       state;
  angle_t           held_inc;
  logic             held_last;
  logic [CNT_W-1:0] beat_cnt;

  logic                              m_valid_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_data_q;
  logic [STRB_W-1:0]                 m_strb_q;
  logic                              m_last_q;

  angle_t sample;
  angle_t inc_new;
  angle_t phase_next;
  logic   out_free;
  logic   last_beat;
  logic   emit;
  logic   accept;
  logic   s_ready;

  // NOTE: every signal here is assigned on every pass through the block, so no
  // latch can be inferred; any future branch must keep that property.
  always_comb begin
    sample    = angle_t'(s00_axis.tdata[PHASE_W-1:0]);
    inc_new   = sample >>> K_SHIFT;
    out_free  = !m_valid_q || m00_axis.tready;
    last_beat = (beat_cnt == LAST_CNT);
    s_ready   = (state == IDLE) || (out_free && last_beat);
    emit      = (state == RUN) && out_free;
    accept    = s00_axis.tvalid && s_ready;
  end

  phase_accumulator u_phase (
    .clk        (s00_axis_aclk),
    .rst        (s00_axis_areset),
    .en         (emit),
    .inc        (held_inc),
    .phase_next (phase_next)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_strb_q  <= '0;
      m_last_q  <= 1'b0;
    end else begin
      if (emit) begin
        m_valid_q <= 1'b1;
        m_data_q  <= C_M00_AXIS_TDATA_WIDTH'({phase_next, AMPLITUDE});
        m_strb_q  <= '1;
        m_last_q  <= held_last && last_beat;
        beat_cnt  <= last_beat ? '0 : beat_cnt + 1'b1;
      end else if (m00_axis.tready) begin
        // Beat taken and nothing new to send; tdata keeps its last value.
        m_valid_q <= 1'b0;
        m_strb_q  <= '0;
        m_last_q  <= 1'b0;
      end

      // A sample arriving on the final beat keeps RUN for back-to-back output.
      if (accept) begin
        state <= RUN;
      end else if (emit && last_beat) begin
        state <= IDLE;
      end
    end
  end

  // NOTE: the held sample is only read while in RUN, so these registers need
  // no reset; leaving it off keeps them out of the reset tree.
  always_ff @(posedge s00_axis_aclk) begin
    if (accept) begin
      held_inc  <= inc_new;
      held_last <= s00_axis.tlast;
    end
  end

  assign s00_axis.tready = s_ready;
  assign m00_axis.tvalid = m_valid_q;
  assign m00_axis.tdata  = m_data_q;
  assign m00_axis.tstrb  = m_strb_q;
  assign m00_axis.tlast  = m_last_q;

  // Sample upper bits and strobes carry no information for the modulator.
  logic unused_s00;
  assign unused_s00 = ^{s00_axis.tstrb,
                        s00_axis.tdata[C_S00_AXIS_TDATA_WIDTH-1:PHASE_W]};

endmodule

// File: tb/tb_fm_modulate.sv
// Self-checking bench for fm_modulate: directed steps plus random samples,
// compared against a queue-based model of the expected beat stream.
module tb_fm_modulate;

  localparam int INTERP = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fm_modulate_if #(.DATA_W(32)) s0 ();
  fm_modulate_if #(.DATA_W(32)) m0 ();
  fm_modulate_if #(.DATA_W(32)) s1 ();
  fm_modulate_if #(.DATA_W(32)) m1 ();

  fm_modulate #(.INTERP(INTERP), .K_SHIFT(0)) dut0 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis        (s0),
    .m00_axis        (m0)
  );

  fm_modulate #(.INTERP(INTERP), .K_SHIFT(4)) dut1 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .s00_axis        (s1),
    .m00_axis        (m1)
  );

  typedef struct {
    logic [15:0] phase;
    logic        last;
  } beat_t;

  beat_t       q0[$];
  beat_t       q1[$];
  logic [15:0] mphase0;
  logic [15:0] mphase1;

  int checks = 0;
  int errors = 0;
  bit acc0, acc1;
  int beats0 = 0;
  int cyc_no = 0;
  bit rand_ready = 0;
  bit watch = 0;
  int first_v, last_v, pkt_beats, tlast_at;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: each accepted sample contributes INTERP beats, each advancing the
  // phase by floor(sample / 2^k) modulo 2^16.
  task automatic model_accept(input int which, input logic [15:0] d, input logic last);
    int    k;
    int    s;
    int    inc;
    beat_t b;
    k   = (which == 0) ? 0 : 4;
    s   = int'($signed(d));
    inc = s >>> k;
    for (int i = 0; i < INTERP; i++) begin
      if (which == 0) begin
        mphase0 = 16'(int'(mphase0) + inc);
        b.phase = mphase0;
      end else begin
        mphase1 = 16'(int'(mphase1) + inc);
        b.phase = mphase1;
      end
      b.last = last && (i == INTERP - 1);
      if (which == 0) q0.push_back(b);
      else            q1.push_back(b);
    end
  endtask

  task automatic check_beat(input int which, input logic [31:0] data,
                            input logic last, input logic [3:0] strb);
    beat_t e;
    int    sz;
    sz = (which == 0) ? q0.size() : q1.size();
    check($sformatf("dut%0d_beat_expected", which), 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      check($sformatf("dut%0d_beat_phase", which), data[31:16], e.phase);
      check($sformatf("dut%0d_beat_amp", which), data[15:0], 16'h7FFF);
      check($sformatf("dut%0d_beat_last", which), last, e.last);
      check($sformatf("dut%0d_beat_strb", which), strb, 4'hF);
    end
  endtask

  // One clock: observe handshakes just before the rising edge, then step past it.
  task automatic cycle();
    @(negedge clk);
    if (watch && m0.tvalid) begin
      if (first_v < 0) first_v = cyc_no;
      last_v = cyc_no;
    end
    if (m0.tvalid && m0.tready) begin
      check_beat(0, m0.tdata, m0.tlast, m0.tstrb);
      beats0++;
      if (watch) begin
        pkt_beats++;
        if (m0.tlast) tlast_at = pkt_beats;
      end
    end
    if (m1.tvalid && m1.tready) check_beat(1, m1.tdata, m1.tlast, m1.tstrb);
    acc0 = s0.tvalid && s0.tready;
    acc1 = s1.tvalid && s1.tready;
    if (acc0) model_accept(0, s0.tdata[15:0], s0.tlast);
    if (acc1) model_accept(1, s1.tdata[15:0], s1.tlast);
    @(posedge clk);
    #1;
    cyc_no++;
    if (rand_ready) m0.tready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input int which, input logic [15:0] d, input logic last);
    int          n;
    logic [15:0] junk;
    n    = 0;
    junk = 16'($urandom);
    if (which == 0) begin
      s0.tdata = {junk, d}; s0.tlast = last; s0.tvalid = 1'b1;
    end else begin
      s1.tdata = {junk, d}; s1.tlast = last; s1.tvalid = 1'b1;
    end
    acc0 = 0;
    acc1 = 0;
    while (!((which == 0) ? acc0 : acc1) && n < 64) begin
      cycle();
      n++;
    end
    check($sformatf("dut%0d_send_accepted", which), 64'(n < 64), 64'd1);
    if (which == 0) begin s0.tvalid = 1'b0; s0.tlast = 1'b0; end
    else            begin s1.tvalid = 1'b0; s1.tlast = 1'b0; end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || m0.tvalid || m1.tvalid) && n < 400) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 64'(n < 400), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tvalid"}, m0.tvalid, 1'b0);
    check({tag, "_tdata"},  m0.tdata,  32'h0);
    check({tag, "_tstrb"},  m0.tstrb,  4'h0);
    check({tag, "_tlast"},  m0.tlast,  1'b0);
    check({tag, "_tready"}, s0.tready, 1'b1);
    check({tag, "_dut1_tready"}, s1.tready, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    q0.delete(); q1.delete();
    mphase0 = '0; mphase1 = '0;
    #2;
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int b;
    s0.tvalid = 0; s0.tdata = '0; s0.tstrb = '1; s0.tlast = 0;
    s1.tvalid = 0; s1.tdata = '0; s1.tstrb = '1; s1.tlast = 0;
    m0.tready = 1; m1.tready = 1;
    #1;
    do_reset();

    // Single sample: latency, ready gap, phase ramp
    send(0, 16'h0100, 1'b0);
    check("t1_no_beat_yet", m0.tvalid, 1'b0);
    check("t1_ready_low0", s0.tready, 1'b0);
    cycle();
    check("t1_first_valid", m0.tvalid, 1'b1);
    check("t1_first_phase", m0.tdata[31:16], 16'h0100);
    check("t1_first_amp", m0.tdata[15:0], 16'h7FFF);
    check("t1_ready_low1", s0.tready, 1'b0);
    cycle();
    check("t1_ready_low2", s0.tready, 1'b0);
    cycle();
    check("t1_ready_back", s0.tready, 1'b1);
    drain("t1");
    check("t1_final_phase", m0.tdata[31:16], 16'h0400);
    check("t1_tvalid_drops", m0.tvalid, 1'b0);

    // Wrap-around, then a negative increment
    do_reset();
    send(0, 16'h7000, 1'b0);
    send(0, 16'hFF00, 1'b0);
    drain("t2");
    check("t2_final_phase", m0.tdata[31:16], 16'hBC00);

    // Deviation shift on the K_SHIFT=4 instance
    send(1, 16'h8000, 1'b0);
    drain("t3");
    check("t3_final_phase", m1.tdata[31:16], 16'hE000);

    // Backpressure mid-sample: presented beat must stay put
    send(0, 16'h0123, 1'b0);
    cycle();
    cycle();
    m0.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_stall_valid", m0.tvalid, 1'b1);
      if (q0.size() != 0) begin
        check("t4_stall_data", m0.tdata, {q0[0].phase, 16'h7FFF});
        check("t4_stall_last", m0.tlast, q0[0].last);
      end
    end
    m0.tready = 1'b1;
    drain("t4");

    // Three-sample packet, back-to-back
    watch = 1; first_v = -1; last_v = -1; pkt_beats = 0; tlast_at = 0;
    send(0, 16'($urandom), 1'b0);
    send(0, 16'($urandom), 1'b0);
    send(0, 16'($urandom), 1'b1);
    drain("t5");
    watch = 0;
    check("t5_beat_count", pkt_beats, 12);
    check("t5_tlast_beat", tlast_at, 12);
    check("t5_continuous_valid", last_v - first_v + 1, 12);

    // Random samples and random downstream stalls
    rand_ready = 1;
    for (int i = 0; i < 24; i++) send(0, 16'($urandom), 1'($urandom_range(0, 1)));
    drain("t6");
    rand_ready = 0;
    m0.tready = 1'b1;

    // Reset in the middle of a sample
    send(0, 16'h0200, 1'b0);
    b = beats0;
    n = 0;
    while (beats0 < b + 2 && n < 20) begin
      cycle();
      n++;
    end
    check("t7_two_beats_seen", 64'(n < 20), 64'd1);
    rst = 1'b1;
    q0.delete(); q1.delete();
    mphase0 = '0; mphase1 = '0;
    #2;
    check_idle_outputs("t7_midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(0, 16'h0010, 1'b0);
    cycle();
    check("t7_first_valid", m0.tvalid, 1'b1);
    check("t7_first_phase", m0.tdata[31:16], 16'h0010);
    drain("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
